// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide with HI/LO result
// registers and a start/busy/done handshake. A single 2*WIDTH accumulator is
// shared between the shift-add multiplier and the restoring divider.
// Optional feature macro: MULDIV_ABORT_EN adds an 'abort' input that cancels
// an operation while it is in RUN or FIX.

module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               rsign_q, rsign_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Shared datapath: operand magnitudes, one iteration of each algorithm and
    // the final sign correction. For multiply, acc holds {partial, multiplier};
    // for divide, acc holds {remainder, dividend/quotient}.
    always_comb begin
        a_neg   = ~op[0] & a[WIDTH-1];
        b_neg   = ~op[0] & b[WIDTH-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;

        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step = {add_sum, acc_q[WIDTH-1:1]};

        shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};
        if (diff[WIDTH]) begin
            div_step = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end

        prod_fix = (~op_q[0] & neg_q) ? -acc_q : acc_q;
        quo_fix  = (~op_q[0] & neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = (~op_q[0] & rsign_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Control: state transitions, operand capture, iteration and HI/LO write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rsign_d = rsign_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op[1] && (b == '0)) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = CNT_W'(WIDTH);
                        op_d    = op;
                        neg_d   = a_neg ^ b_neg;
                        rsign_d = a_neg;
                        dz_d    = 1'b0;
                        opnd_d  = op[1] ? b_mag : a_mag;
                        acc_d   = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                    end
                end
            end
            RUN: begin
                acc_d = op_q[1] ? div_step : mul_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef MULDIV_ABORT_EN
        if (abort && ((state_q == RUN) || (state_q == FIX))) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
`endif
    end

    // Registered handshake outputs: busy follows the next state, done and
    // div_zero pulse for the cycle after the DONE state.
    always_comb begin
        busy_d     = (state_d != IDLE);
        done_d     = (state_q == DONE);
        div_zero_d = (state_q == DONE) && dz_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            rsign_q    <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            rsign_q    <= rsign_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: a 32-bit and an 8-bit instance share stimulus
// signals; 'sel' chooses which one receives start and which one is observed.
// Expected HI/LO/div_zero/latency come from a behavioural model in the bench
// and travel through a scoreboard queue.

module tb_muldiv_unit;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_r = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        start32, start8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    logic        busy32, done32, dz32;
    logic        busy8, done8, dz8;

    logic [31:0] obs_hi, obs_lo;
    logic        obs_busy, obs_done, obs_dz;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          c0 = 0;
    logic [31:0] model_hi [2];
    logic [31:0] model_lo [2];
    exp_t        sb_q [$];

    // Free-running clock and edge counter used for latency measurement.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign start32  = start_r & ~sel;
    assign start8   = start_r & sel;
    assign obs_hi   = sel ? {24'h0, hi8} : hi32;
    assign obs_lo   = sel ? {24'h0, lo8} : lo32;
    assign obs_busy = sel ? busy8 : busy32;
    assign obs_done = sel ? done8 : done32;
    assign obs_dz   = sel ? dz8 : dz32;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk      (clk),
        .reset    (reset),
`ifdef MULDIV_ABORT_EN
        .abort    (1'b0),
`endif
        .start    (start32),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_out   (hi32),
        .lo_out   (lo32),
        .busy     (busy32),
        .done     (done32),
        .div_zero (dz32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .reset    (reset),
`ifdef MULDIV_ABORT_EN
        .abort    (1'b0),
`endif
        .start    (start8),
        .op       (op),
        .a        (a[7:0]),
        .b        (b[7:0]),
        .hi_out   (hi8),
        .lo_out   (lo8),
        .busy     (busy8),
        .done     (done8),
        .div_zero (dz8)
    );

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: arithmetic on 64-bit integers, truncated to width w.
    task automatic model(input int s, input logic [1:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, output exp_t e);
        int     w;
        longint mask, ua, ub, sa, sb, p, q, r;
        w    = s ? 8 : 32;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(aa) & mask;
        ub   = longint'(bb) & mask;
        sa   = aa[w-1] ? ua - (longint'(1) << w) : ua;
        sb   = bb[w-1] ? ub - (longint'(1) << w) : ub;
        e.dz = 1'b0;
        case (o)
            2'b00: begin
                p = sa * sb;
                model_hi[s] = 32'((p >> w) & mask);
                model_lo[s] = 32'(p & mask);
            end
            2'b01: begin
                p = ua * ub;
                model_hi[s] = 32'((p >> w) & mask);
                model_lo[s] = 32'(p & mask);
            end
            2'b10: begin
                if (sb == 0) begin
                    e.dz = 1'b1;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    model_hi[s] = 32'(r & mask);
                    model_lo[s] = 32'(q & mask);
                end
            end
            default: begin
                if (ub == 0) begin
                    e.dz = 1'b1;
                end else begin
                    q = ua / ub;
                    r = ua % ub;
                    model_hi[s] = 32'(r & mask);
                    model_lo[s] = 32'(q & mask);
                end
            end
        endcase
        e.hi  = model_hi[s];
        e.lo  = model_lo[s];
        e.lat = e.dz ? 1 : w + 2;
    endtask

    // Drive one start pulse (edge E0), push the expected result; returns at
    // the falling edge just after E0.
    task automatic applyStimulus(input bit s, input logic [1:0] o, input logic [31:0] aa,
                                 input logic [31:0] bb, input string tag);
        exp_t e;
        model(s, o, aa, bb, e);
        e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        sel     = s;
        op      = o;
        a       = aa;
        b       = bb;
        start_r = 1'b1;
        c0      = cyc;
        @(negedge clk);
        start_r = 1'b0;
    endtask

    // Wait (bounded) for done, pop the scoreboard and compare everything.
    task automatic checkOutput();
        exp_t e;
        int   n;
        n = 0;
        while (!obs_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = sb_q.pop_front();
        if (!obs_done) begin
            compare({e.tag, "_timeout"}, 64'(obs_done), 64'(1));
        end else begin
            compare({e.tag, "_hi"}, 64'(obs_hi), 64'(e.hi));
            compare({e.tag, "_lo"}, 64'(obs_lo), 64'(e.lo));
            compare({e.tag, "_dz"}, 64'(obs_dz), 64'(e.dz));
            compare({e.tag, "_busy"}, 64'(obs_busy), 64'(0));
            compare({e.tag, "_lat"}, 64'(cyc - c0 - 1), 64'(e.lat));
            @(negedge clk);
            compare({e.tag, "_pulse"}, 64'(obs_done), 64'(0));
        end
    endtask

    initial begin
        bit seen;
        model_hi[0] = '0; model_lo[0] = '0;
        model_hi[1] = '0; model_lo[1] = '0;

        repeat (2) @(negedge clk);
        compare("rst_hi32", 64'(hi32), 64'(0));
        compare("rst_lo32", 64'(lo32), 64'(0));
        compare("rst_busy32", 64'(busy32), 64'(0));
        compare("rst_done32", 64'(done32), 64'(0));
        compare("rst_dz32", 64'(dz32), 64'(0));
        compare("rst_hi8", 64'(hi8), 64'(0));
        compare("rst_lo8", 64'(lo8), 64'(0));
        compare("rst_busy8", 64'(busy8), 64'(0));
        reset = 1'b0;

        applyStimulus(0, 2'b00, 32'hFFFF_FFFF, 32'h2, "mult_m1x2");
        checkOutput();

        applyStimulus(0, 2'b01, 32'hFFFF_FFFF, 32'h2, "multu_ffx2");
        repeat (3) @(negedge clk);
        compare("multu_busy_mid", 64'(obs_busy), 64'(1));
        start_r = 1'b1; op = 2'b11; a = 32'd9; b = 32'd0;
        @(negedge clk);
        start_r = 1'b0;
        checkOutput();

        applyStimulus(0, 2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minsq");
        checkOutput();
        applyStimulus(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        checkOutput();
        applyStimulus(0, 2'b00, 32'hFFFF_FFFD, 32'd5, "mult_m3x5");
        checkOutput();

        applyStimulus(0, 2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7d2");
        checkOutput();
        applyStimulus(0, 2'b10, 32'd7, 32'hFFFF_FFFE, "div_7dm2");
        checkOutput();
        applyStimulus(0, 2'b11, 32'hFFFF_FFFF, 32'h10, "divu_big");
        checkOutput();
        applyStimulus(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_minm1");
        checkOutput();

        applyStimulus(0, 2'b11, 32'd100, 32'd7, "divu_100d7");
        checkOutput();

        // Divide by zero while start stays high through the busy cycle.
        applyStimulus(0, 2'b10, 32'd55, 32'd0, "div_zero");
        start_r = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start_r = 1'b0;
        checkOutput();
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= obs_done | obs_busy;
        end
        compare("dz_no_extra_op", 64'(seen), 64'(0));

        // Reset in the middle of a MULTU discards it.
        @(negedge clk);
        sel = 0; op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        compare("midrst_hi", 64'(obs_hi), 64'(0));
        compare("midrst_lo", 64'(obs_lo), 64'(0));
        compare("midrst_busy", 64'(obs_busy), 64'(0));
        compare("midrst_done", 64'(obs_done), 64'(0));
        compare("midrst_dz", 64'(obs_dz), 64'(0));
        reset = 1'b0;
        model_hi[0] = '0; model_lo[0] = '0;
        model_hi[1] = '0; model_lo[1] = '0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= obs_done;
        end
        compare("midrst_no_done", 64'(seen), 64'(0));

        applyStimulus(0, 2'b00, 32'd12345, 32'hFFFF_FF00, "mult_postrst");
        checkOutput();

        // 8-bit instance corner cases.
        applyStimulus(1, 2'b10, 32'h80, 32'hFF, "w8_div_minm1");
        checkOutput();
        applyStimulus(1, 2'b11, 32'hFF, 32'h10, "w8_divu");
        checkOutput();
        applyStimulus(1, 2'b00, 32'h80, 32'hFF, "w8_mult");
        checkOutput();
        applyStimulus(1, 2'b10, 32'h07, 32'h00, "w8_div_zero");
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with internal HI/LO result registers and a start/done handshake. It supports signed and unsigned multiply and divide, detects divide-by-zero, and shares one datapath between both operations. It replaces the separate mult/div blocks, their HI/LO muxes and the HI/LO registers in the multicycle CPU. The control unit drives `start` and `op`, stalls on `busy` and reads `hi_out`/`lo_out`.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH+1), iteration counter width (derived; do not override).

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend; sampled with `start`.
- `b`  in  WIDTH  multiplier / divisor; sampled with `start`.
- `hi_out`  out  WIDTH  HI register: product upper half or remainder.
- `lo_out`  out  WIDTH  LO register: product lower half or quotient.
- `busy`  out  1  high from the edge that accepts `start` until the edge that returns to IDLE.
- `done`  out  1  one-cycle pulse when an operation completes (including divide-by-zero).
- `div_zero`  out  1  one-cycle pulse, coincident with `done`, on DIV/DIVU with `b == 0`.
- `abort`  in  1  present only with `MULDIV_ABORT_EN`.

## Operation
- States: IDLE, RUN, FIX, DONE.
- **IDLE, start=1, valid op:** latch |a|, |b| (raw values for unsigned ops), the result-sign bits and `op`; load counter = WIDTH; go to RUN; `busy` = 1.
- **IDLE, start=1, div op, b == 0:** go to DONE with the dz flag set; counter unused.
- **RUN:** one iteration per cycle; counter decrements; go to FIX when the counter reaches 0.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring divide; remainder WIDTH+1 bits, quotient shifted in LSB-first.
- **FIX:** sign correction, then write HI/LO; go to DONE.
  - Signed multiply: negate the 2·WIDTH product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - All arithmetic is modulo 2^WIDTH per half.
  - Most-negative / −1 yields quotient = most-negative and remainder = 0, with no flag.
- **DONE:** `done` = 1, `div_zero` = dz, `busy` = 0; next edge goes to IDLE.
- HI/LO are unchanged on divide-by-zero and hold their values until the next successful FIX.
- `start` is ignored outside IDLE, including during the DONE cycle. There is no queueing.

## Timing
- Reset values: `hi_out` = 0, `lo_out` = 0, `busy` = 0, `done` = 0, `div_zero` = 0; state = IDLE.
- Let E0 be the edge that samples `start`. `busy` rises after E0.
  - Normal operation: RUN occupies E1..E_WIDTH; FIX is at E_WIDTH+1, when HI/LO update; `done` is high in the cycle after E_WIDTH+2.
  - Total latency is WIDTH+2 edges from E0 (34 for WIDTH = 32).
- Divide-by-zero: DONE follows E0, so `done` and `div_zero` are high after E1; latency is 1 edge.
- `hi_out` and `lo_out` are valid from FIX onward and remain stable while `done` is high.
- Reset asserted in any state returns all outputs to reset values at that edge and discards the in-flight operation. Reset has priority over `start` and `abort`.

## Configuration
- Macro: `MULDIV_ABORT_EN`.
- When defined:
  - The `abort` input exists.
  - `abort` = 1 while in RUN or FIX returns the unit to IDLE at that edge: `busy` = 0, no `done`, HI/LO unchanged.
  - `abort` in IDLE or DONE has no effect.
  - `abort` takes priority over RUN→FIX and FIX→DONE.
- When undefined: no `abort` port; every accepted operation runs to completion.

## Test plan
- MULT with a = 0xFFFFFFFF, b = 0x00000002 (WIDTH = 32) → `hi_out` = 0xFFFFFFFF, `lo_out` = 0xFFFFFFFE; `done` is seen exactly 34 edges after E0.
- MULTU with the same operands → `hi_out` = 0x00000001, `lo_out` = 0xFFFFFFFE.
- DIV a = 0xFFFFFFF9 (−7), b = 2 → `lo_out` = 0xFFFFFFFD, `hi_out` = 0xFFFFFFFF.
- DIVU a = 100, b = 7 → `lo_out` = 0x0000000E, `hi_out` = 0x00000002.
- DIV with b = 0 after a prior result of HI = 2, LO = 0xE → `done` and `div_zero` high after E1; HI/LO still 2 / 0xE; `start` pulsed while `busy` is ignored.
- Reset asserted 10 cycles into a MULTU → all outputs 0 the next cycle and no `done`. Also run WIDTH = 8 DIV 0x80 / 0xFF → `lo_out` = 0x80, `hi_out` = 0x00, latency 10 edges.
